// File: rtl/wb_write_port_ctrl.sv
// Register-bank write-port controller: merges single-cycle ALU results with
// buffered multi-cycle results and tracks pending multi-cycle destinations.
module wb_write_port_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_rd,
    input  logic [31:0]                 alu_value,
    input  logic                        mc_valid,
    input  logic [4:0]                  mc_rd,
    input  logic [31:0]                 mc_value,
    output logic                        mc_ready,
    input  logic                        mc_issue,
    input  logic [4:0]                  mc_issue_rd,
    input  logic [4:0]                  chk_rs1,
    input  logic [4:0]                  chk_rs2,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    output logic                        regwrite,
    output logic [4:0]                  rd,
    output logic [31:0]                 rd_value,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        protocol_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [4:0]    fifo_rd  [FIFO_DEPTH];
    logic [31:0]   fifo_val [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          wb_from_mc;
    logic [31:0]   busy;
    logic [31:0]   busy_next;
    logic          issue_conflict;
    logic          orphan_result;

    // mc handshake: a result transfers on the rising edge where
    // mc_valid && mc_ready; the producer keeps mc_rd/mc_value stable while
    // mc_valid && !mc_ready. mc_ready depends only on occupancy.
    assign mc_ready = (fifo_count != FULL_COUNT);
    assign push     = mc_valid && mc_ready;
    assign pop      = !alu_valid && (fifo_count != '0);

    assign rs1_busy = (chk_rs1 != 5'd0) && busy[chk_rs1];
    assign rs2_busy = (chk_rs2 != 5'd0) && busy[chk_rs2];

    assign issue_conflict = mc_issue && (mc_issue_rd != 5'd0) && busy[mc_issue_rd];
    assign orphan_result  = push && (mc_rd != 5'd0) && !busy[mc_rd];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]  <= mc_rd;
            fifo_val[wr_ptr] <= mc_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!push && pop) fifo_count <= fifo_count - CW'(1);
        end
    end

    // x0 entries are still consumed but never produce a bank write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite   <= 1'b0;
            rd         <= '0;
            rd_value   <= '0;
            wb_from_mc <= 1'b0;
        end else if (alu_valid) begin
            regwrite   <= (alu_rd != 5'd0);
            rd         <= alu_rd;
            rd_value   <= alu_value;
            wb_from_mc <= 1'b0;
        end else if (pop) begin
            regwrite   <= (fifo_rd[rd_ptr] != 5'd0);
            rd         <= fifo_rd[rd_ptr];
            rd_value   <= fifo_val[rd_ptr];
            wb_from_mc <= 1'b1;
        end else begin
            regwrite   <= 1'b0;
            wb_from_mc <= 1'b0;
        end
    end

    // Clear applies as the bank captures an mc write; a new issue overrides it.
    always_comb begin
        busy_next = busy;
        if (regwrite && wb_from_mc) busy_next[rd] = 1'b0;
        if (mc_issue && (mc_issue_rd != 5'd0)) busy_next[mc_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            protocol_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (issue_conflict || orphan_result) protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_write_port_ctrl.sv
// Bench for wb_write_port_ctrl: ALU vector table, directed multi-cycle
// sequences, and randomized traffic against a queue-based reference model.
module tb_wb_write_port_ctrl;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_value;
    logic          mc_valid;
    logic [4:0]    mc_rd;
    logic [31:0]   mc_value;
    logic          mc_ready;
    logic          mc_issue;
    logic [4:0]    mc_issue_rd;
    logic [4:0]    chk_rs1;
    logic [4:0]    chk_rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          regwrite;
    logic [4:0]    rd;
    logic [31:0]   rd_value;
    logic [CW-1:0] fifo_count;
    logic          protocol_err;

    wb_write_port_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_value(mc_value), .mc_ready(mc_ready),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .regwrite(regwrite), .rd(rd), .rd_value(rd_value),
        .fifo_count(fifo_count), .protocol_err(protocol_err)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [36:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_value = 0;
        mc_valid = 0; mc_rd = 0; mc_value = 0;
        mc_issue = 0; mc_issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    // ---------------- ALU vector table ----------------
    typedef struct {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_value;
        logic        exp_wr;
        logic        check_data;
        logic [4:0]  exp_rd;
        logic [31:0] exp_value;
    } alu_vec_t;

    localparam int NV = 8;
    alu_vec_t vecs[NV];

    task automatic run_alu_table();
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[3] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 1'b1, 5'd1,  32'h00000000};
        vecs[4] = '{1'b1, 5'd16, 32'hA5A5A5A5, 1'b1, 1'b1, 5'd16, 32'hA5A5A5A5};
        vecs[5] = '{1'b0, 5'd9,  32'h12345678, 1'b0, 1'b1, 5'd16, 32'hA5A5A5A5};
        vecs[6] = '{1'b0, 5'd3,  32'h0BADF00D, 1'b0, 1'b1, 5'd16, 32'hA5A5A5A5};
        vecs[7] = '{1'b1, 5'd2,  32'hCAFEF00D, 1'b1, 1'b1, 5'd2,  32'hCAFEF00D};
        for (int i = 0; i < NV; i++) begin
            alu_valid = vecs[i].alu_valid;
            alu_rd    = vecs[i].alu_rd;
            alu_value = vecs[i].alu_value;
            step();
            check($sformatf("vec%0d_regwrite", i), regwrite, vecs[i].exp_wr);
            if (vecs[i].check_data) begin
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
                check($sformatf("vec%0d_value", i), rd_value, vecs[i].exp_value);
            end
        end
        alu_valid = 0;
    endtask

    // ---------------- reference model for random traffic ----------------
    logic [36:0] m_q[$];
    logic [4:0]  pend_q[$];
    logic [31:0] m_busy;
    logic        m_err, m_wr, m_from_mc;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    logic        offer_active;
    logic [4:0]  offer_rd;
    logic [31:0] offer_val;

    task automatic run_random(input int ncyc);
        logic [36:0] e;
        logic [4:0]  r;
        logic [31:0] nb;
        logic        acc;
        int          alu_pct;
        m_q.delete(); pend_q.delete(); exp_q.delete();
        m_busy = '0; m_err = 0; m_wr = 0; m_from_mc = 0; m_rd = 0; m_val = 0;
        offer_active = 0; offer_rd = 0; offer_val = 0;
        for (int c = 0; c < ncyc; c++) begin
            check("rnd_regwrite", regwrite, m_wr);
            if (regwrite) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL rnd_extra_write: got rd=%0d value 0x%0h, expected no write", rd, rd_value);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_write", {rd, rd_value}, e);
                end
            end
            check("rnd_err", protocol_err, m_err);

            // Heavy ALU traffic first to exercise starvation and full FIFO.
            alu_pct   = (c < ncyc / 2) ? 70 : 20;
            alu_valid = ($urandom_range(0, 99) < alu_pct);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_value = $urandom;
            mc_issue = 0; mc_issue_rd = 0;
            if ($urandom_range(0, 3) == 0) begin
                r = 5'($urandom_range(1, 31));
                if (!m_busy[r]) begin
                    mc_issue = 1; mc_issue_rd = r;
                end
            end
            if (!offer_active) begin
                if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    offer_active = 1; offer_rd = pend_q.pop_front(); offer_val = $urandom;
                end else if ($urandom_range(0, 19) == 0) begin
                    offer_active = 1; offer_rd = 0; offer_val = $urandom;
                end
            end
            mc_valid = offer_active;
            mc_rd    = offer_active ? offer_rd : 5'($urandom_range(0, 31));
            mc_value = offer_active ? offer_val : $urandom;
            chk_rs1  = 5'($urandom_range(0, 31));
            chk_rs2  = 5'($urandom_range(0, 31));
            #1;
            check("rnd_count", fifo_count, m_q.size());
            check("rnd_ready", mc_ready, m_q.size() != DEPTH);
            check("rnd_rs1_busy", rs1_busy, chk_rs1 != 0 && m_busy[chk_rs1]);
            check("rnd_rs2_busy", rs2_busy, chk_rs2 != 0 && m_busy[chk_rs2]);

            acc = mc_valid && (m_q.size() != DEPTH);
            if (mc_issue && mc_issue_rd != 0 && m_busy[mc_issue_rd]) m_err = 1;
            if (acc && mc_rd != 0 && !m_busy[mc_rd]) m_err = 1;
            nb = m_busy;
            if (m_wr && m_from_mc) nb[m_rd] = 1'b0;
            if (mc_issue && mc_issue_rd != 0) nb[mc_issue_rd] = 1'b1;
            if (alu_valid) begin
                m_wr = (alu_rd != 0); m_from_mc = 0; m_rd = alu_rd; m_val = alu_value;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_wr = (e[36:32] != 0); m_from_mc = 1; m_rd = e[36:32]; m_val = e[31:0];
            end else begin
                m_wr = 0; m_from_mc = 0;
            end
            if (acc) begin
                m_q.push_back({mc_rd, mc_value});
                offer_active = 0;
            end
            m_busy = nb;
            if (m_wr) exp_q.push_back({m_rd, m_val});
            if (mc_issue) pend_q.push_back(mc_issue_rd);
            step();
        end
        idle_inputs();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [36:0] e;
        int pushed;
        int got;
        rst = 0;
        idle_inputs();
        reset_dut();
        rst = 1;
        #1;
        check("rst_regwrite", regwrite, 0);
        check("rst_rd", rd, 0);
        check("rst_value", rd_value, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", mc_ready, 1);
        check("rst_err", protocol_err, 0);
        step();
        rst = 0;

        run_alu_table();

        // Reset mid-burst with three entries queued and an error pending.
        reset_dut();
        chk_rs1 = 12;
        for (int i = 0; i < 3; i++) begin
            mc_issue = 1; mc_issue_rd = 5'(10 + i); step();
        end
        mc_issue = 0;
        alu_valid = 1; alu_rd = 1; alu_value = 32'h55;
        mc_valid = 1; mc_rd = 10; mc_value = 1; step();
        mc_rd = 11; step();
        mc_rd = 20; step();
        mc_valid = 0;
        check("burst_count", fifo_count, 3);
        check("burst_err", protocol_err, 1);
        check("burst_regwrite", regwrite, 1);
        check("burst_rs1_busy", rs1_busy, 1);
        rst = 1; alu_valid = 0;
        #2;
        check("midrst_regwrite", regwrite, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_ready", mc_ready, 1);
        check("midrst_rs1_busy", rs1_busy, 0);
        check("midrst_err", protocol_err, 0);
        step();
        rst = 0;

        // Multi-cycle latency and scoreboard timing.
        reset_dut();
        mc_issue = 1; mc_issue_rd = 7; chk_rs1 = 7; step();
        mc_issue = 0;
        check("mc_busy_c1", rs1_busy, 1); step();
        check("mc_busy_c2", rs1_busy, 1); step();
        check("mc_busy_c3", rs1_busy, 1);
        check("mc_ready_c3", mc_ready, 1);
        mc_valid = 1; mc_rd = 7; mc_value = 32'h1234; step();
        mc_valid = 0;
        check("mc_busy_c4", rs1_busy, 1);
        check("mc_regwrite_c4", regwrite, 0);
        check("mc_count_c4", fifo_count, 1); step();
        check("mc_regwrite_c5", regwrite, 1);
        check("mc_rd_c5", rd, 7);
        check("mc_value_c5", rd_value, 32'h1234);
        check("mc_busy_c5", rs1_busy, 1);
        check("mc_count_c5", fifo_count, 0); step();
        check("mc_busy_c6", rs1_busy, 0);
        check("mc_regwrite_c6", regwrite, 0);
        check("mc_rd_hold_c6", rd, 7);
        check("mc_err", protocol_err, 0);

        // Full FIFO under sustained ALU traffic, then drain.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            mc_issue = 1; mc_issue_rd = 5'(13 + i); step();
        end
        mc_issue = 0;
        alu_valid = 1; alu_rd = 2; alu_value = 32'hA1A10000;
        for (int i = 0; i < 4; i++) begin
            mc_valid = 1; mc_rd = 5'(13 + i); mc_value = 32'h200 + i;
            check($sformatf("fill%0d_ready", i), mc_ready, 1);
            step();
        end
        mc_valid = 1; mc_rd = 0; mc_value = 32'hBAD;
        check("full_count", fifo_count, 4);
        check("full_ready", mc_ready, 0);
        step();
        check("full_hold_count", fifo_count, 4);
        mc_valid = 0; alu_valid = 0;
        check("full_no_bypass", mc_ready, 0);
        check("full_alu_write", regwrite, 1);
        check("full_alu_rd", rd, 2);
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_regwrite", i), regwrite, 1);
            check($sformatf("drain%0d_rd", i), rd, 13 + i);
            check($sformatf("drain%0d_value", i), rd_value, 32'h200 + i);
            step();
        end
        chk_rs1 = 16;
        check("drain_done_regwrite", regwrite, 0);
        check("drain_done_ready", mc_ready, 1);
        check("drain_done_count", fifo_count, 0);
        check("drain_rs1_busy", rs1_busy, 0);
        check("drain_err", protocol_err, 0);

        // Pointer wrap: ten entries with ALU bubbles in between.
        reset_dut();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            mc_issue = 1; mc_issue_rd = 5'(17 + i); step();
        end
        mc_issue = 0;
        pushed = 0; got = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            if (regwrite && rd != 5'd4) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL wrap_extra: got rd=%0d value 0x%0h, expected no write", rd, rd_value);
                end else begin
                    e = exp_q.pop_front();
                    check("wrap_order", {rd, rd_value}, e);
                    got++;
                end
            end
            mc_valid = 0;
            alu_valid = (c % 3 == 1); alu_rd = 4; alu_value = 32'hF00 + c;
            if (pushed < 10 && mc_ready) begin
                mc_valid = 1; mc_rd = 5'(17 + pushed); mc_value = 32'h100 + pushed;
                exp_q.push_back({mc_rd, mc_value});
                pushed++;
            end
            step();
        end
        idle_inputs();
        check("wrap_got", got, 10);
        check("wrap_err", protocol_err, 0);

        // Protocol errors.
        reset_dut();
        mc_issue = 1; mc_issue_rd = 3; step();
        check("err_first_issue", protocol_err, 0);
        step();
        mc_issue = 0;
        check("err_double_issue", protocol_err, 1);
        step();
        check("err_sticky", protocol_err, 1);
        reset_dut();
        check("err_after_reset", protocol_err, 0);
        mc_valid = 1; mc_rd = 9; mc_value = 32'h99; step();
        mc_valid = 0;
        check("err_orphan", protocol_err, 1);

        reset_dut();
        run_random(400);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/wb_write_port_ctrl.md
# wb_write_port_ctrl

Write-port controller that drives the single write port (regwrite, rd, rd_value) of the integer register bank. It merges single-cycle ALU results with results from multi-cycle units (divider, load unit) into one write per cycle. Multi-cycle results are buffered in a small FIFO behind a valid/ready handshake. A 32-entry busy scoreboard lets the issue stage stall on operands whose multi-cycle result has not reached the register bank.

## Interface
Parameters:
- FIFO_DEPTH, 4, multi-cycle result buffer depth; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  single-cycle result present this cycle; never stalled.
- alu_rd  in  5  ALU destination register.
- alu_value  in  32  ALU result.
- mc_valid  in  1  multi-cycle result offered.
- mc_rd  in  5  multi-cycle destination register.
- mc_value  in  32  multi-cycle result.
- mc_ready  out  1  FIFO can accept; transfer occurs when mc_valid && mc_ready.
- mc_issue  in  1  multi-cycle op issued this cycle.
- mc_issue_rd  in  5  destination of the issued multi-cycle op.
- chk_rs1  in  5  issue-stage operand 1 index.
- chk_rs2  in  5  issue-stage operand 2 index.
- rs1_busy  out  1  combinational; busy[chk_rs1], forced to 0 for x0.
- rs2_busy  out  1  combinational; busy[chk_rs2], forced to 0 for x0.
- regwrite  out  1  registered; write enable to the register bank.
- rd  out  5  registered; write address.
- rd_value  out  32  registered; write data.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- protocol_err  out  1  sticky error flag; cleared only by rst.

## Operation
- Reset: regwrite=0, rd=0, rd_value=0, FIFO empty, fifo_count=0, busy vector cleared, protocol_err=0. mc_ready=1 after reset because it is derived from the count. Reset mid-operation discards all FIFO contents and pending busy bits.
- mc_ready = (fifo_count != FIFO_DEPTH). No full-bypass: while full, a same-cycle pop does not raise mc_ready.
- Push: when mc_valid && mc_ready, {mc_rd, mc_value} is written at the FIFO tail. Pointers wrap modulo FIFO_DEPTH.
- Write-port select, one write per cycle with fixed priority:
  - If alu_valid, the ALU result is registered to the outputs.
  - Otherwise, if the FIFO is non-empty, the head is popped and registered.
  - Otherwise regwrite=0, and rd and rd_value hold their previous values.
- ALU priority is absolute. Sustained alu_valid may starve the FIFO, in which case mc_ready falls once the FIFO is full.
- rd=0: the entry is still consumed, but regwrite=0 for that cycle.
- Simultaneous push and pop: fifo_count is unchanged. A push into an empty FIFO is not popped in the same cycle.
- Scoreboard, busy[31:0]:
  - Set: mc_issue with mc_issue_rd≠0 sets the bit at the next edge.
  - Clear: a bit clears on the edge at which the bank captures a write that came from the FIFO path. Condition: regwrite=1, internal registered flag wb_from_mc=1, and rd matches.
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never change the scoreboard.
- protocol_err is set, and stays set until rst, on either of:
  - mc_issue to a register that is already busy;
  - an accepted mc result with mc_rd≠0 whose busy bit is 0.

## Timing
- ALU path: alu_valid in cycle N gives regwrite=1 in cycle N+1. The bank holds the value from cycle N+2.
- MC path, empty FIFO, no ALU traffic: handshake in cycle N, pop in cycle N+1, regwrite=1 in cycle N+2. The busy bit clears at the end of N+2, so rsX_busy is low from N+3, when the bank already holds the value.
- Scoreboard: mc_issue in cycle N gives rsX_busy=1 from cycle N+1.
- fifo_count and mc_ready reflect the state at the start of the cycle.

## Test plan
- Reset: assert rst mid-burst with 3 entries queued. Required: regwrite=0, fifo_count=0, mc_ready=1, rs1_busy=0, protocol_err=0 immediately, no edge needed.
- ALU only: alu_valid with alu_rd=5, alu_value=0xDEADBEEF in cycle 0. Required: cycle 1 shows regwrite=1, rd=5, rd_value=0xDEADBEEF. With alu_rd=0, regwrite=0.
- MC latency and scoreboard: mc_issue rd=7 in cycle 0; mc result rd=7, value 0x1234 handshakes in cycle 3. Required: rs1_busy=1 (chk_rs1=7) in cycles 1-5; regwrite=1, rd=7 in cycle 5; rs1_busy=0 in cycle 6.
- Full and starvation: hold alu_valid=1, push 4 mc results. Required: fifo_count=4, mc_ready=0. After dropping alu_valid, pops occur on 4 consecutive cycles in FIFO order, then mc_ready=1.
- Pointer wrap: push and pop 10 entries with values 0x100 to 0x109, interleaved with ALU bubbles. Required: writes appear in order with no loss or duplication.
- Errors: mc_issue rd=3 twice without a result → protocol_err=1. After a new reset, an mc result with rd=9 and no prior issue → protocol_err=1.
